// File: rtl/avalon_ram_responder.sv
// Avalon-MM on-chip RAM responder: fixed-latency, in-order response pipeline
// with an outstanding-transaction limit exposed through s_busy.
module avalon_ram_responder #(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          MemBytes       = 16384,
    parameter int          ReadLatency    = 1,
    parameter int          MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_addr,
    input  logic [3:0]  s_be,
    input  logic [31:0] s_wdata,
    output logic        s_busy,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_resp,
    output logic        s_wrespvalid
);

    localparam int AddrBits = $clog2(MemBytes);
    localparam int IdxBits  = (AddrBits > 2) ? AddrBits - 2 : 1;
    localparam int Words    = MemBytes / 4;
    localparam int CntBits  = $clog2(MaxOutstanding + 1);
    localparam int Last     = ReadLatency - 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecErr = 2'b11;

    logic [31:0]            mem [Words];
    logic [CntBits-1:0]     inflight;
    logic [31:0]            offset;
    logic [IdxBits-1:0]     idx;
    logic [31:0]            rd_word;
    logic                   in_range;
    logic                   is_write;
    logic                   accept;
    logic                   rsp_fire;

    logic [ReadLatency-1:0] pipe_valid;
    logic [ReadLatency-1:0] pipe_write;
    logic [1:0]             pipe_resp  [ReadLatency];
    logic [31:0]            pipe_rdata [ReadLatency];

    // Address decode: offsets below BaseAddr wrap to large values, so the
    // lower-bound test must stay explicit.
    assign offset   = s_addr - BaseAddr;
    assign in_range = (s_addr >= BaseAddr) && (offset < 32'(MemBytes));
    assign idx      = offset[IdxBits+1:2];
    assign rd_word  = mem[idx];

    // Busy depends only on the registered counter; write wins when both
    // request strobes are high.
    assign s_busy   = (inflight == CntBits'(MaxOutstanding));
    assign is_write = s_write;
    assign accept   = (s_read | s_write) & ~s_busy;
    assign rsp_fire = pipe_valid[Last];

    // RAM has no reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && is_write && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (s_be[b]) begin
                    mem[idx][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_write <= '0;
            for (int i = 0; i < ReadLatency; i++) begin
                pipe_resp[i]  <= RespOkay;
                pipe_rdata[i] <= '0;
            end
            inflight <= '0;
        end else begin
            // Stage 0 carries zeroed fields when idle so outputs read as 0.
            pipe_valid[0] <= accept;
            pipe_write[0] <= accept & is_write;
            pipe_resp[0]  <= (accept && !in_range) ? RespDecErr : RespOkay;
            pipe_rdata[0] <= (accept && !is_write && in_range) ? rd_word : 32'h0;
            for (int i = 1; i < ReadLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_write[i] <= pipe_write[i-1];
                pipe_resp[i]  <= pipe_resp[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
            if (accept && !rsp_fire) begin
                inflight <= inflight + CntBits'(1);
            end else if (!accept && rsp_fire) begin
                inflight <= inflight - CntBits'(1);
            end
        end
    end

    assign s_rvalid     = pipe_valid[Last] & ~pipe_write[Last];
    assign s_wrespvalid = pipe_valid[Last] &  pipe_write[Last];
    assign s_resp       = pipe_resp[Last];
    assign s_rdata      = pipe_rdata[Last];

`ifndef SYNTHESIS
    a_no_dual_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(s_read && s_write));
    a_rsp_needs_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (s_rvalid || s_wrespvalid) |-> (inflight != '0));
    a_no_accept_when_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> !s_busy);
    a_inflight_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        inflight <= CntBits'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Directed bench: instance A uses default latency/limits, instance B uses
// ReadLatency=3 and MaxOutstanding=2 for the back-pressure and reset scenarios.
module tb_avalon_ram_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_read, a_write, a_busy, a_rvalid, a_wrespvalid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic [1:0]  a_resp;

    logic        b_read, b_write, b_busy, b_rvalid, b_wrespvalid;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic [1:0]  b_resp;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] b_vals [5] = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003,
                                32'h0BAD_0004, 32'h0BAD_0005};
    logic [31:0] alt_vals [6] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h1234_5678,
                                  32'h8765_4321, 32'hA5A5_5A5A, 32'h0F0F_F0F0};

    always #5 clk = ~clk;

    avalon_ram_responder dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .s_read(a_read), .s_write(a_write), .s_addr(a_addr), .s_be(a_be), .s_wdata(a_wdata),
        .s_busy(a_busy), .s_rvalid(a_rvalid), .s_rdata(a_rdata), .s_resp(a_resp),
        .s_wrespvalid(a_wrespvalid)
    );

    avalon_ram_responder #(.ReadLatency(3), .MaxOutstanding(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .s_read(b_read), .s_write(b_write), .s_addr(b_addr), .s_be(b_be), .s_wdata(b_wdata),
        .s_busy(b_busy), .s_rvalid(b_rvalid), .s_rdata(b_rdata), .s_resp(b_resp),
        .s_wrespvalid(b_wrespvalid)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        a_read = rd; a_write = wr; a_addr = addr; a_be = be; a_wdata = data;
    endtask

    task automatic b_drive(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        b_read = rd; b_write = wr; b_addr = addr; b_be = be; b_wdata = data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        a_drive(0, 0, 0, 0, 0);
        b_drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_busy, a_rvalid, a_wrespvalid, a_resp, a_rdata} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_a: busy=%b rvalid=%b wresp=%b resp=%b rdata=%h, required all 0",
                     a_busy, a_rvalid, a_wrespvalid, a_resp, a_rdata);
        end
        n_cmp++;
        if ({b_busy, b_rvalid, b_wrespvalid, b_resp, b_rdata} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_b: busy=%b rvalid=%b wresp=%b resp=%b rdata=%h, required all 0",
                     b_busy, b_rvalid, b_wrespvalid, b_resp, b_rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        a_drive(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        tick();
        a_drive(1, 0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_wrespvalid, a_rvalid, a_resp} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_resp: wresp=%b rvalid=%b resp=%b, required 1 0 00",
                     a_wrespvalid, a_rvalid, a_resp);
        end
        tick();
        a_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({a_rvalid, a_wrespvalid, a_resp} !== 4'b1000 || a_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_after_wr: rvalid=%b wresp=%b resp=%b rdata=%h, required 1 0 00 deadbeef",
                     a_rvalid, a_wrespvalid, a_resp, a_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rvalid_pulse: rvalid=%b rdata=%h, required 0 00000000", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_byte_enable();
        a_drive(0, 1, 32'h20, 4'hF, 32'h11223344);
        tick();
        a_drive(0, 1, 32'h20, 4'b0010, 32'hAABBCCDD);
        tick();
        a_drive(0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF);
        tick();
        a_drive(1, 0, 32'h20, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_wrespvalid, a_resp} !== 3'b100) begin
            n_fail++;
            $display("FAIL be_zero_resp: wresp=%b resp=%b, required 1 00", a_wrespvalid, a_resp);
        end
        tick();
        a_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h1122CC44) begin
            n_fail++;
            $display("FAIL be_merge: rvalid=%b rdata=%h, required 1 1122cc44", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_decode_error();
        a_drive(0, 1, 32'h0, 4'hF, 32'hCAFEF00D);
        tick();
        a_drive(0, 1, 32'h3FFC, 4'hF, 32'h600DF00D);
        tick();
        a_drive(1, 0, 32'h4000, 4'h0, 32'h0);
        tick();
        a_drive(0, 1, 32'h4000, 4'hF, 32'h12345678);
        @(negedge clk);
        n_cmp++;
        if ({a_rvalid, a_wrespvalid, a_resp} !== 4'b1011 || a_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: rvalid=%b wresp=%b resp=%b rdata=%h, required 1 0 11 00000000",
                     a_rvalid, a_wrespvalid, a_resp, a_rdata);
        end
        tick();
        a_drive(1, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({a_wrespvalid, a_rvalid, a_resp} !== 4'b1011) begin
            n_fail++;
            $display("FAIL oor_write: wresp=%b rvalid=%b resp=%b, required 1 0 11",
                     a_wrespvalid, a_rvalid, a_resp);
        end
        tick();
        a_drive(1, 0, 32'h3FFC, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_resp !== 2'b00 || a_rdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL oor_no_alias: rvalid=%b resp=%b rdata=%h, required 1 00 cafef00d",
                     a_rvalid, a_resp, a_rdata);
        end
        tick();
        a_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_resp !== 2'b00 || a_rdata !== 32'h600DF00D) begin
            n_fail++;
            $display("FAIL top_word: rvalid=%b resp=%b rdata=%h, required 1 00 600df00d",
                     a_rvalid, a_resp, a_rdata);
        end
    endtask

    task automatic test_alternating();
        a_drive(0, 1, 32'h40, 4'hF, alt_vals[0]);
        for (int i = 0; i < 6; i++) begin
            tick();
            a_drive(1, 0, 32'h40, 4'h0, 32'h0);
            @(negedge clk);
            n_cmp++;
            if ({a_wrespvalid, a_rvalid} !== 2'b10) begin
                n_fail++;
                $display("FAIL alt_wresp[%0d]: wresp=%b rvalid=%b, required 1 0", i, a_wrespvalid, a_rvalid);
            end
            tick();
            if (i < 5) a_drive(0, 1, 32'h40, 4'hF, alt_vals[i+1]);
            else       a_drive(0, 0, 0, 0, 0);
            @(negedge clk);
            n_cmp++;
            if ({a_rvalid, a_wrespvalid} !== 2'b10 || a_rdata !== alt_vals[i]) begin
                n_fail++;
                $display("FAIL alt_read[%0d]: rvalid=%b wresp=%b rdata=%h, required 1 0 %h",
                         i, a_rvalid, a_wrespvalid, a_rdata, alt_vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [5];
        int rsp_cyc [5];
        logic [31:0] rsp_dat [5];
        logic busy_hist [40];
        int exp_acc [5] = '{0, 1, 4, 5, 8};
        int na = 0;
        int nr = 0;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            b_drive(0, 1, 32'h100 + 32'(4 * i), 4'hF, b_vals[i]);
            tick();
            b_drive(0, 0, 0, 0, 0);
            repeat (4) tick();
        end
        b_drive(1, 0, 32'h100, 4'h0, 32'h0);
        for (int c = 0; c < 40 && nr < 5; c++) begin
            @(negedge clk);
            busy_hist[c] = b_busy;
            if (b_rvalid) begin
                if (nr < 5) begin
                    rsp_cyc[nr] = c;
                    rsp_dat[nr] = b_rdata;
                end
                nr++;
            end
            acc = b_read && !b_busy;
            if (acc) begin
                acc_cyc[na] = c;
                na++;
            end
            tick();
            if (acc) begin
                if (na < 5) b_drive(1, 0, 32'h100 + 32'(4 * na), 4'h0, 32'h0);
                else        b_drive(0, 0, 0, 0, 0);
            end
        end
        b_drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (na != 5 || nr != 5) begin
            n_fail++;
            $display("FAIL b2b_timeout: accepts=%0d responses=%0d, required 5 5", na, nr);
        end else begin
            n_cmp++;
            if (busy_hist[acc_cyc[0]+1] !== 1'b0 || busy_hist[acc_cyc[0]+2] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy_rise: busy@+1=%b busy@+2=%b, required 0 1",
                         busy_hist[acc_cyc[0]+1], busy_hist[acc_cyc[0]+2]);
            end
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (acc_cyc[i] - acc_cyc[0] != exp_acc[i]) begin
                    n_fail++;
                    $display("FAIL b2b_accept[%0d]: offset=%0d, required %0d", i,
                             acc_cyc[i] - acc_cyc[0], exp_acc[i]);
                end
                n_cmp++;
                if (rsp_cyc[i] - acc_cyc[i] != 3) begin
                    n_fail++;
                    $display("FAIL b2b_latency[%0d]: latency=%0d, required 3", i, rsp_cyc[i] - acc_cyc[i]);
                end
                n_cmp++;
                if (rsp_dat[i] !== b_vals[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: rdata=%h, required %h", i, rsp_dat[i], b_vals[i]);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_midflight();
        logic saw_rvalid = 1'b0;
        logic found = 1'b0;
        b_drive(1, 0, 32'h100, 4'h0, 32'h0);
        tick();
        b_drive(1, 0, 32'h104, 4'h0, 32'h0);
        tick();
        b_drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (b_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy: busy=%b, required 1", b_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (b_busy !== 1'b0 || b_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_clear: busy=%b rvalid=%b, required 0 0", b_busy, b_rvalid);
        end
        repeat (2) begin
            @(negedge clk);
            if (b_rvalid) saw_rvalid = 1'b1;
        end
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (b_rvalid) saw_rvalid = 1'b1;
        end
        n_cmp++;
        if (saw_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_dropped: stray rvalid=%b, required 0", saw_rvalid);
        end
        tick();
        b_drive(1, 0, 32'h100, 4'h0, 32'h0);
        a_drive(1, 0, 32'h10, 4'h0, 32'h0);
        tick();
        b_drive(0, 0, 0, 0, 0);
        a_drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rst_ram_keep_a: rvalid=%b rdata=%h, required 1 deadbeef", a_rvalid, a_rdata);
        end
        for (int c = 0; c < 10 && !found; c++) begin
            if (b_rvalid) begin
                found = 1'b1;
                n_cmp++;
                if (b_rdata !== b_vals[0]) begin
                    n_fail++;
                    $display("FAIL rst_ram_keep_b: rdata=%h, required %h", b_rdata, b_vals[0]);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rst_ram_keep_b: no rvalid within 10 cycles, required one response");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_decode_error();
        test_alternating();
        test_back_to_back();
        test_reset_midflight();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
